// File: rtl/div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_pkg : shared result codes and FSM encoding for the divide sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_OV  = 2'b01,
    ST_DBZ = 2'b10,
    ST_TMO = 2'b11
  } div_status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/div_op_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_op_fifo : 2-entry in-order buffer for dividend/divisor operand pairs
// Revision: 1.0
// ---------------------------------------------------------------------------
module div_op_fifo #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_dividend,
  input  logic [DW-1:0] push_divisor,
  output logic [DW-1:0] head_dividend,
  output logic [DW-1:0] head_divisor,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_dvd [2];
  logic [DW-1:0] mem_dvs [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full          = (count == 2'd2);
  assign empty         = (count == 2'd0);
  assign do_push       = push & ~full;
  assign do_pop        = pop & ~empty;
  assign head_dividend = mem_dvd[rd_ptr];
  assign head_divisor  = mem_dvs[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_dvd[wr_ptr] <= push_dividend;
      mem_dvs[wr_ptr] <= push_divisor;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_job_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_job_sequencer : buffers operand pairs, runs one divider job at a time
// with timeout, and presents results on a valid/ready output.
// Revision: 1.0
// ---------------------------------------------------------------------------
module div_job_sequencer
  import div_pkg::*;
#(
  parameter int DW  = 8,
  parameter int TMO = 63
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_dividend,
  input  logic [DW-1:0] in_divisor,
  output logic          div_start,
  output logic [DW-1:0] div_dividend,
  output logic [DW-1:0] div_divisor,
  input  logic          div_finish,
  input  logic          div_ov,
  input  logic          div_dbz,
  input  logic [DW-1:0] div_quot,
  input  logic [DW-1:0] div_rem,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_quot,
  output logic [DW-1:0] out_rem,
  output logic [1:0]    out_status,
  output logic          busy
);

  localparam int            TW    = (TMO < 1) ? 1 : $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_T = TW'(TMO);

  seq_state_e    state;
  seq_state_e    state_nx;
  logic [TW-1:0] timer;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          launch;
  logic          done_hit;
  div_status_e   done_code;
  logic [DW-1:0] head_dvd;
  logic [DW-1:0] head_dvs;

  assign in_ready  = ~fifo_full;
  assign push      = in_valid & in_ready;
  assign launch    = (state == S_IDLE) & ~fifo_empty & ~out_valid;
  assign div_start = (state == S_START);
  assign busy      = (state != S_IDLE) | ~fifo_empty | out_valid;

  div_op_fifo #(.DW(DW)) u_fifo (
    .CLK           (CLK),
    .RST           (RST),
    .push          (push),
    .pop           (launch),
    .push_dividend (in_dividend),
    .push_divisor  (in_divisor),
    .head_dividend (head_dvd),
    .head_divisor  (head_dvs),
    .full          (fifo_full),
    .empty         (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    done_hit  = 1'b0;
    done_code = ST_OK;
    case (state)
      S_IDLE:  if (launch) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (div_finish) begin
          done_hit  = 1'b1;
          done_code = ST_OK;
        end else if (div_dbz) begin
          done_hit  = 1'b1;
          done_code = ST_DBZ;
        end else if (div_ov) begin
          done_hit  = 1'b1;
          done_code = ST_OV;
        end else if (timer == TMO_T) begin
          done_hit  = 1'b1;
          done_code = ST_TMO;
        end
        if (done_hit) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The result is latched as the job leaves WAIT so out_valid rises one
  // cycle after the completion is sampled; DONE is then a single turnaround.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_valid    <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_status   <= ST_OK;
    end else begin
      if (launch) begin
        div_dividend <= head_dvd;
        div_divisor  <= head_dvs;
      end
      if (state == S_START)
        timer <= '0;
      else if ((state == S_WAIT) && !done_hit)
        timer <= timer + 1'b1;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (done_hit) begin
        out_valid  <= 1'b1;
        out_status <= done_code;
        out_quot   <= (done_code == ST_OK) ? div_quot : '0;
        out_rem    <= (done_code == ST_OK) ? div_rem  : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_job_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_job_sequencer : directed bench with a scripted divider model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_div_job_sequencer;
  import div_pkg::*;

  localparam int DW  = 8;
  localparam int TMO = 63;
  localparam int K_FIN = 0, K_DBZ = 1, K_OV = 2, K_BOTH = 3, K_SIL = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dividend = '0;
  logic [DW-1:0] in_divisor = '0;
  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic          div_finish = 1'b0;
  logic          div_ov = 1'b0;
  logic          div_dbz = 1'b0;
  logic [DW-1:0] div_quot = '0;
  logic [DW-1:0] div_rem = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_quot;
  logic [DW-1:0] out_rem;
  logic [1:0]    out_status;
  logic          busy;

  div_job_sequencer #(.DW(DW), .TMO(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_finish(div_finish), .div_ov(div_ov), .div_dbz(div_dbz),
    .div_quot(div_quot), .div_rem(div_rem),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .out_status(out_status),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Scripted divider: job n (n-th div_start) answers per the tables below.
  int         job_kind  [16];
  int         job_delay [16];
  logic [7:0] job_q     [16];
  logic [7:0] job_r     [16];
  int         start_cyc [16];
  int         starts = 0;
  int         cur = 0;
  int         cnt = 0;
  bit         pend = 0;

  always @(negedge CLK) begin
    div_finish = 1'b0; div_ov = 1'b0; div_dbz = 1'b0;
    div_quot = '0; div_rem = '0;
    if (RST) begin
      pend = 0;
    end else begin
      if (pend) begin
        cnt++;
        if (cnt == job_delay[cur]) begin
          pend = 0;
          div_quot = 8'hAA; div_rem = 8'h55;
          case (job_kind[cur])
            K_FIN:  begin div_finish = 1'b1; div_quot = job_q[cur]; div_rem = job_r[cur]; end
            K_DBZ:  div_dbz = 1'b1;
            K_OV:   div_ov = 1'b1;
            K_BOTH: begin div_ov = 1'b1; div_dbz = 1'b1; end
            default: ;
          endcase
        end
      end
      if (div_start) begin
        cur = (starts < 16) ? starts : 15;
        start_cyc[cur] = cyc;
        starts++;
        cnt = 0;
        pend = (job_kind[cur] != K_SIL);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) begin
        @(posedge CLK);
        ok = 1;
      end else begin
        @(negedge CLK);
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_out(output int oc);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1;
    end
    oc = cyc;
    check("out_valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [1:0] st, input logic [7:0] q, input logic [7:0] r);
    check({tag, "_status"}, 32'(out_status), 32'(st));
    check({tag, "_quot"},   32'(out_quot),   32'(q));
    check({tag, "_rem"},    32'(out_rem),    32'(r));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check({tag, "_cleared"}, 32'(out_valid), 32'd0);
  endtask

  task automatic consume(input string tag, input logic [1:0] st, input logic [7:0] q, input logic [7:0] r, output int oc);
    wait_out(oc);
    check_result(tag, st, q, r);
    release_out(tag);
  endtask

  int oc;

  initial begin
    job_kind = '{default: K_SIL};
    job_delay = '{default: 1};
    job_q = '{default: 8'h00};
    job_r = '{default: 8'h00};
    start_cyc = '{default: 0};
    job_kind[0] = K_FIN;  job_delay[0] = 12; job_q[0] = 8'd14; job_r[0] = 8'd2;
    job_kind[1] = K_DBZ;  job_delay[1] = 3;
    job_kind[2] = K_FIN;  job_delay[2] = 4;  job_q[2] = 8'd14; job_r[2] = 8'd2;
    job_kind[3] = K_FIN;  job_delay[3] = 4;  job_q[3] = 8'd4;  job_r[3] = 8'd1;
    job_kind[4] = K_FIN;  job_delay[4] = 4;  job_q[4] = 8'd20; job_r[4] = 8'd0;
    job_kind[5] = K_SIL;
    job_kind[6] = K_BOTH; job_delay[6] = 5;
    job_kind[7] = K_OV;   job_delay[7] = 2;
    job_kind[8] = K_SIL;
    job_kind[9] = K_FIN;  job_delay[9] = 6;  job_q[9] = 8'd6;  job_r[9] = 8'd2;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_div_dvd",   32'(div_dividend), 32'd0);
    check("rst_div_dvs",   32'(div_divisor),  32'd0);
    check_result("rst", 2'b00, 8'd0, 8'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Normal divide 100/7, finish 12 cycles after start
    push(8'd100, 8'd7);
    wait_out(oc);
    check("norm_latency", 32'(oc), 32'(start_cyc[0] + 13));
    check("norm_div_dvd", 32'(div_dividend), 32'd100);
    check("norm_div_dvs", 32'(div_divisor),  32'd7);
    check_result("norm", 2'b00, 8'd14, 8'd2);
    repeat (3) @(negedge CLK);
    check("norm_hold_valid", 32'(out_valid), 32'd1);
    check_result("norm_hold", 2'b00, 8'd14, 8'd2);
    check("norm_busy", 32'(busy), 32'd1);
    release_out("norm");

    // Divide by zero 50/0
    push(8'd50, 8'd0);
    consume("dbz", 2'b10, 8'd0, 8'd0, oc);
    repeat (10) @(negedge CLK);
    check("dbz_one_start", 32'(starts), 32'd2);

    // Ordering and backpressure A, B, C
    push(8'd100, 8'd7);
    push(8'd9, 8'd2);
    push(8'd200, 8'd10);
    check("ord_in_ready_full", 32'(in_ready), 32'd0);
    check("ord_busy", 32'(busy), 32'd1);
    wait_out(oc);
    check_result("ord_a", 2'b00, 8'd14, 8'd2);
    repeat (4) @(negedge CLK);
    check("ord_hold_full", 32'(in_ready), 32'd0);
    release_out("ord_a");
    consume("ord_b", 2'b00, 8'd4, 8'd1, oc);
    wait_out(oc);
    check("ord_c_div_dvd", 32'(div_dividend), 32'd200);
    check_result("ord_c", 2'b00, 8'd20, 8'd0);
    release_out("ord_c");

    // Timeout with a silent divider
    push(8'd1, 8'd1);
    wait_out(oc);
    check("tmo_latency", 32'(oc), 32'(start_cyc[5] + 65));
    check_result("tmo", 2'b11, 8'd0, 8'd0);
    release_out("tmo");

    // div_ov and div_dbz together, then div_ov alone
    push(8'd77, 8'd3);
    consume("both", 2'b10, 8'd0, 8'd0, oc);
    push(8'd255, 8'd1);
    consume("ov", 2'b01, 8'd0, 8'd0, oc);

    // Reset during WAIT with another job buffered
    push(8'd3, 8'd1);
    repeat (10) @(negedge CLK);
    push(8'd4, 8'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_div_start", 32'(div_start), 32'd0);
    check("mrst_in_ready",  32'(in_ready),  32'd1);
    check("mrst_busy",      32'(busy),      32'd0);
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    check("mrst_no_stale", 32'(out_valid), 32'd0);
    check("mrst_no_relaunch", 32'(starts), 32'd9);
    check("mrst_idle_busy", 32'(busy), 32'd0);

    // Operation resumes after reset: 20/3
    push(8'd20, 8'd3);
    consume("resume", 2'b00, 8'd6, 8'd2, oc);
    check("resume_latency", 32'(oc), 32'(start_cyc[9] + 7));
    @(negedge CLK);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_job_sequencer.md
DIV_JOB_SEQUENCER -- requirements
Module: div_job_sequencer

Interface
REQ-001 Parameter DW, default 8: operand and result width in bits.
REQ-002 Parameter TMO, default 63: wait-cycle timeout limit for one job.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  upstream offers an operand pair.
REQ-006 in_ready  out  1  sequencer can accept an operand pair.
REQ-007 in_dividend  in  DW, and in_divisor  in  DW: the operand pair.
REQ-008 div_start  out  1  start pulse to the divider controller.
REQ-009 div_dividend  out  DW, and div_divisor  out  DW: operands held stable for the divider.
REQ-010 div_finish  in  1  divider completion pulse.
REQ-011 div_ov  in  1  divider overflow flag.
REQ-012 div_dbz  in  1  divider divide-by-zero flag.
REQ-013 div_quot  in  DW, and div_rem  in  DW: divider results, valid with div_finish.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  downstream accepts the result.
REQ-016 out_quot  out  DW, and out_rem  out  DW: result data.
REQ-017 out_status  out  2  result code: 00 ok, 01 overflow, 10 divide-by-zero, 11 timeout.
REQ-018 busy  out  1  any job is buffered, in flight or pending output.

Function
REQ-019 Input buffering shall be a 2-entry FIFO in order.
- in_ready = FIFO not full.
- A push occurs when in_valid and in_ready are both high.
REQ-020 The FSM shall have four states: IDLE, START, WAIT, DONE.
REQ-021 IDLE shall launch a job only when the FIFO is non-empty and out_valid is 0.
- On launch: copy the FIFO head to div_dividend/div_divisor, pop the head, go to START.
REQ-022 START shall hold div_start=1 for exactly one cycle, clear the timer, and go to WAIT.
- div_start shall be 0 in every other state.
REQ-023 div_dividend/div_divisor shall remain unchanged from launch until the job leaves WAIT.
REQ-024 WAIT shall evaluate, in priority order, each cycle:
- div_finish: status 00, capture div_quot/div_rem.
- else div_dbz: status 10.
- else div_ov: status 01.
- else timer==TMO: status 11.
- else increment the timer and stay in WAIT.
REQ-025 On a completion in WAIT, the sequencer shall go to DONE.
- For status 01/10/11, out_quot and out_rem shall be 0.
REQ-026 DONE shall register the result, set out_valid=1 on the following edge, and return to IDLE.
REQ-027 Timing:
- Completion sampled in WAIT at cycle K gives out_valid high from cycle K+1.
- A launch decided in cycle L gives div_start high in cycle L+1.
REQ-028 out_valid, out_quot, out_rem and out_status shall hold stable until out_ready is sampled high.
- out_valid shall clear on the edge where out_valid and out_ready are both high.
REQ-029 A push and a launch pop in the same cycle shall both take effect; the count is unchanged.
REQ-030 The timer shall be ceil(log2(TMO+1)) bits wide and shall never wrap.
REQ-031 busy = (state != IDLE) | FIFO non-empty | out_valid.

Reset
REQ-032 While RST is high, the sequencer shall be in the following reset state:
- state = IDLE, FIFO empty, timer = 0.
- div_start = 0, div_dividend = 0, div_divisor = 0.
- out_valid = 0, out_quot = 0, out_rem = 0, out_status = 00, busy = 0.
- in_ready = 1.
REQ-033 RST asserted mid-job shall discard the in-flight and buffered jobs.
- No result is produced for discarded jobs.
- After release, operation resumes from IDLE.

Structure
REQ-034 The shared package div_pkg shall hold:
- The status codes OK / OV / DBZ / TMO.
- The FSM state encoding.
REQ-035 The FIFO shall be a separate sub-module div_op_fifo (parameter DW, depth 2, signals push/pop/full/empty).

Verification
REQ-036 Normal divide: push 100/7; model returns div_finish 12 cycles after div_start with q=14, r=2.
- Required: out_valid with status 00, q=14, r=2.
REQ-037 Divide-by-zero: push 50/0; model raises div_dbz.
- Required: status 10, q=0, r=0, one div_start pulse only.
REQ-038 Ordering and backpressure: out_ready=0; push jobs A, B, C.
- Required: in_ready low after A is launched and B, C are buffered.
- Required: results come out in order A, B, C as out_ready toggles.
REQ-039 Timeout: model silent, TMO=63, div_start in cycle N.
- Required: out_valid high in cycle N+65 with status 11.
REQ-040 Simultaneous div_ov and div_dbz in one cycle: required status 10.
REQ-041 RST pulse during WAIT.
- Required: out_valid=0, div_start=0, in_ready=1, busy=0.
- Required: no stale result after release.
